fetch_sequencer: RTL

//  Control FSM that sequences program_counter through fetch, issue, execute and advance.

---
 rtl/fetch_sequencer_if.sv | 38 +++
 rtl/fetch_sequencer.sv | 74 +++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch_sequencer bus (master = sequencer): run/pc in, memory req/ack, instr valid/ready, exec results, PC controls, status
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  run;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_opcode;
  logic [DATA_WIDTH-1:0] instr_op1;
  logic [DATA_WIDTH-1:0] instr_op2;
  logic                  exec_done;
  logic                  exec_jump;
  logic [ADDR_WIDTH-1:0] exec_jump_addr;
  logic                  exec_halt;
  logic                  halt;
  logic                  jump_en;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic [1:0]            instr_size;
  logic                  halted;
  logic [CNT_WIDTH-1:0]  retired;
  modport master (
    input  run, pc, mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_jump_addr, exec_halt,
    output mem_req, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2,
           halt, jump_en, jump_addr, instr_size, halted, retired
  );
  modport slave (
    output run, pc, mem_ack, mem_rdata, instr_ready, exec_done, exec_jump, exec_jump_addr, exec_halt,
    input  mem_req, mem_addr, instr_valid, instr_opcode, instr_op1, instr_op2,
           halt, jump_en, jump_addr, instr_size, halted, retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/issue/execute/advance FSM; ports clk, rst, bus (master: byte memory req/ack, instr valid/ready, exec_done results, program_counter halt/jump/size, halted/retired)
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic rst,
  fetch_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, EXECUTE, ADVANCE, HALTED} state_t;
  state_t state, nxt;
  logic [1:0] sz, dec;
  logic ack;
  logic [ADDR_WIDTH-1:0] addr_d;
  assign ack = bus.mem_req & bus.mem_ack;
  assign dec = bus.mem_rdata[7:6] == 2'b01 ? 2'd2 : bus.mem_rdata[7:6] == 2'b10 ? 2'd3 : 2'd1;
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = bus.run ? FETCH_OP : IDLE;
      FETCH_OP: nxt = !ack ? FETCH_OP : dec == 2'd1 ? ISSUE : FETCH_B1;
      FETCH_B1: nxt = !ack ? FETCH_B1 : sz == 2'd2 ? ISSUE : FETCH_B2;
      FETCH_B2: nxt = ack ? ISSUE : FETCH_B2;
      ISSUE:    nxt = bus.instr_ready ? EXECUTE : ISSUE;
      EXECUTE:  nxt = !bus.exec_done ? EXECUTE : bus.exec_halt ? HALTED : ADVANCE;
      ADVANCE:  nxt = bus.run ? FETCH_OP : IDLE;
      default:  nxt = HALTED;
    endcase
  end
  // mem_addr is registered, so leaving ADVANCE it must use the pc that program_counter loads on that same edge
  always_comb begin
    addr_d = (ack && nxt != ISSUE) ? bus.mem_addr + ADDR_WIDTH'(1) :
             state == IDLE ? bus.pc :
             state == ADVANCE ? (bus.jump_en ? bus.jump_addr : bus.pc + ADDR_WIDTH'(bus.instr_size)) :
             bus.mem_addr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req      <= 1'b0;
      bus.mem_addr     <= '0;
      bus.instr_valid  <= 1'b0;
      bus.instr_opcode <= '0;
      bus.instr_op1    <= '0;
      bus.instr_op2    <= '0;
      bus.halt         <= 1'b1;
      bus.jump_en      <= 1'b0;
      bus.jump_addr    <= '0;
      bus.instr_size   <= 2'd0;
      bus.halted       <= 1'b0;
      bus.retired      <= '0;
      sz               <= 2'd0;
    end else begin
      bus.mem_req     <= nxt inside {FETCH_OP, FETCH_B1, FETCH_B2};
      bus.mem_addr    <= addr_d;
      bus.instr_valid <= nxt == ISSUE;
      bus.halt        <= nxt != ADVANCE;
      bus.halted      <= nxt == HALTED;
      bus.jump_en     <= nxt == ADVANCE && bus.exec_jump;
      bus.jump_addr   <= nxt == ADVANCE ? bus.exec_jump_addr : '0;
      bus.instr_size  <= nxt == ADVANCE ? sz : 2'd0;
      if (nxt == ADVANCE) bus.retired <= bus.retired + CNT_WIDTH'(1);
      if (state == FETCH_OP && ack) begin
        bus.instr_opcode <= bus.mem_rdata;
        bus.instr_op1    <= '0;
        bus.instr_op2    <= '0;
        sz               <= dec;
      end
      if (state == FETCH_B1 && ack) bus.instr_op1 <= bus.mem_rdata;
      if (state == FETCH_B2 && ack) bus.instr_op2 <= bus.mem_rdata;
    end
  end
endmodule
